// File: rtl/mio_bus_responder.sv
// Responder end of the SCPU memory/IO bus: word-addressed RAM, GPIO output register,
// switch input port and a free-running cycle counter behind a wait-stated handshake.
module mio_bus_responder #(
  parameter int RAM_AW      = 6,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] Addr_bus,
  input  logic [31:0] Data_out,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  input  logic [15:0] sw_i,
  output logic [15:0] gpio_o,
  output logic        bus_err
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [29:0] GPIO_WADDR = 30'h3800_0000;
  localparam logic [29:0] SW_WADDR   = 30'h3C00_0000;
  localparam logic [29:0] CNT_WADDR  = 30'h3C00_0001;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic [15:0] gpio_q, gpio_d;
  logic [31:0] counter_q, counter_d;
  logic        err_q, err_d;

  logic [31:0] ram_q [RAM_DEPTH];
  logic        ram_we;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0] ram_rdata;

  logic        ram_hit;
  logic        gpio_hit;
  logic        sw_hit;
  logic        cnt_hit;
  logic        unmapped;
  logic [31:0] read_mux;

  logic        unused_addr_bits;
  assign unused_addr_bits = ^Addr_bus[1:0];

  // Decode always works on the latched word address, never the live bus.
  assign ram_idx   = addr_q[RAM_AW-1:0];
  assign ram_rdata = ram_q[ram_idx];
  assign ram_hit   = (addr_q[29:RAM_AW] == '0);
  assign gpio_hit  = (addr_q == GPIO_WADDR);
  assign sw_hit    = (addr_q == SW_WADDR);
  assign cnt_hit   = (addr_q == CNT_WADDR);
  assign unmapped  = !(ram_hit || gpio_hit || sw_hit || cnt_hit);

  always_comb begin
    read_mux = 32'h0;
    if (ram_hit) begin
      read_mux = ram_rdata;
    end else if (gpio_hit) begin
      read_mux = {16'h0, gpio_q};
    end else if (sw_hit) begin
      read_mux = {16'h0, sw_i};
    end else if (cnt_hit) begin
      read_mux = counter_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ready_d   = ready_q;
    gpio_d    = gpio_q;
    err_d     = err_q;
    counter_d = counter_q + 32'd1;
    ram_we    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (CPU_MIO) begin
          addr_d  = Addr_bus[31:2];
          we_d    = mem_w;
          wdata_d = Data_out;
          cnt_d   = 4'(WAIT_STATES);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Access edge: commit the write or capture read data, then strobe ready.
          if (we_q) begin
            if (ram_hit) begin
              ram_we = 1'b1;
            end else if (gpio_hit) begin
              gpio_d = wdata_q[15:0];
            end
          end else begin
            rdata_d = read_mux;
          end
          if (unmapped) begin
            err_d = 1'b1;
          end
          ready_d = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        ready_d = 1'b0;
        rdata_d = 32'h0;
        state_d = ST_IDLE;
      end
      default: begin
        ready_d = 1'b0;
        rdata_d = 32'h0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 30'h0;
      we_q      <= 1'b0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      ready_q   <= 1'b0;
      gpio_q    <= 16'h0;
      counter_q <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      gpio_q    <= gpio_d;
      counter_q <= counter_d;
      err_q     <= err_d;
    end
  end

  // RAM contents survive reset; a reset before the access edge leaves ram_we low.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_idx] <= wdata_q;
    end
  end

  assign Data_in   = rdata_q;
  assign MIO_ready = ready_q;
  assign gpio_o    = gpio_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder (default parameters: RAM_AW=6, WAIT_STATES=1).
module tb_mio_bus_responder;

  logic        clk;
  logic        rst_n;
  logic        CPU_MIO;
  logic        mem_w;
  logic [31:0] Addr_bus;
  logic [31:0] Data_out;
  logic [31:0] Data_in;
  logic        MIO_ready;
  logic [15:0] sw_i;
  logic [15:0] gpio_o;
  logic        bus_err;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chkRead;
    logic [31:0] expData;
    logic [15:0] expGpio;
  } vec_t;

  vec_t vecs[14];

  mio_bus_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .CPU_MIO   (CPU_MIO),
    .mem_w     (mem_w),
    .Addr_bus  (Addr_bus),
    .Data_out  (Data_out),
    .Data_in   (Data_in),
    .MIO_ready (MIO_ready),
    .sw_i      (sw_i),
    .gpio_o    (gpio_o),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called just after an edge with the DUT idle; returns read data and edges from accept to ready.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output int lat);
    CPU_MIO  = 1'b1;
    mem_w    = we;
    Addr_bus = addr;
    Data_out = wdata;
    @(posedge clk); #1;
    lat   = -1;
    rdata = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (MIO_ready) begin
        lat   = k;
        rdata = Data_in;
        break;
      end
    end
    CPU_MIO = 1'b0;
    mem_w   = 1'b0;
    testCount++;
    if (lat < 0) begin
      failCount++;
      $display("[TB] FAIL timeout addr=%h: no MIO_ready in 20 cycles, expected one within 2", addr);
    end else begin
      @(posedge clk); #1;
      checkOutput("ready_width", {31'h0, MIO_ready}, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at 200000, expected finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd, rd2;
    int lat, pulses, first, prev, quiet;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0,          16'h0000};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h1234_5678, 16'h0000};
    vecs[2]  = '{1'b1, 32'hE000_0000, 32'h0000_A5A5, 1'b0, 32'h0,          16'hA5A5};
    vecs[3]  = '{1'b0, 32'hE000_0000, 32'h0,         1'b1, 32'h0000_A5A5, 16'hA5A5};
    vecs[4]  = '{1'b0, 32'hF000_0000, 32'h0,         1'b1, 32'h0000_00FF, 16'hA5A5};
    vecs[5]  = '{1'b1, 32'hF000_0000, 32'hDEAD_BEEF, 1'b0, 32'h0,          16'hA5A5};
    vecs[6]  = '{1'b0, 32'hF000_0000, 32'h0,         1'b1, 32'h0000_00FF, 16'hA5A5};
    vecs[7]  = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 1'b0, 32'h0,          16'hA5A5};
    vecs[8]  = '{1'b0, 32'h0000_00FF, 32'h0,         1'b1, 32'hCAFE_F00D, 16'hA5A5};
    vecs[9]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h1234_5678, 16'hA5A5};
    vecs[10] = '{1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0,          16'hA5A5};
    vecs[11] = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h1111_1111, 16'hA5A5};
    vecs[12] = '{1'b1, 32'hE000_0003, 32'hFFFF_1234, 1'b0, 32'h0,          16'h1234};
    vecs[13] = '{1'b0, 32'hE000_0000, 32'h0,         1'b1, 32'h0000_1234, 16'h1234};

    rst_n    = 1'b0;
    CPU_MIO  = 1'b0;
    mem_w    = 1'b0;
    Addr_bus = 32'h0;
    Data_out = 32'h0;
    sw_i     = 16'h00FF;
    #1;
    checkOutput("rst_ready",   {31'h0, MIO_ready}, 32'h0);
    checkOutput("rst_data_in", Data_in, 32'h0);
    checkOutput("rst_gpio",    {16'h0, gpio_o}, 32'h0);
    checkOutput("rst_bus_err", {31'h0, bus_err}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      if (vecs[i].chkRead) begin
        checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].expData);
      end
      checkOutput($sformatf("vec%0d_gpio", i), {16'h0, gpio_o}, {16'h0, vecs[i].expGpio});
      checkOutput($sformatf("vec%0d_bus_err", i), {31'h0, bus_err}, 32'h0);
    end

    // Counter reads whose access edges are 11 cycles apart.
    applyStimulus(1'b0, 32'hF000_0004, 32'h0, rd, lat);
    repeat (7) begin
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 32'hF000_0004, 32'h0, rd2, lat);
    checkOutput("counter_delta", rd2 - rd, 32'd11);

    // Bus inputs change and CPU_MIO drops right after acceptance.
    applyStimulus(1'b1, 32'h0000_0024, 32'h0BAD_BEEF, rd, lat);
    CPU_MIO  = 1'b1;
    mem_w    = 1'b1;
    Addr_bus = 32'h0000_0020;
    Data_out = 32'hAAAA_5555;
    @(posedge clk); #1;
    CPU_MIO  = 1'b0;
    mem_w    = 1'b0;
    Addr_bus = 32'h0000_0024;
    Data_out = 32'h0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (MIO_ready) begin
        lat = k;
        break;
      end
    end
    checkOutput("dropped_latency", 32'(lat), 32'd2);
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0000_0020, 32'h0, rd, lat);
    checkOutput("latched_wdata", rd, 32'hAAAA_5555);
    applyStimulus(1'b0, 32'h0000_0024, 32'h0, rd, lat);
    checkOutput("latched_addr", rd, 32'h0BAD_BEEF);

    // CPU_MIO held high: one ready every 4 cycles, alias 0x13 hits word 4.
    CPU_MIO  = 1'b1;
    mem_w    = 1'b0;
    Addr_bus = 32'h0000_0013;
    pulses = 0;
    first  = -1;
    prev   = -1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (MIO_ready) begin
        pulses++;
        checkOutput("held_rdata", Data_in, 32'h1234_5678);
        if (first < 0) begin
          first = k;
        end else begin
          checkOutput("held_gap", 32'(k - prev), 32'd4);
        end
        prev = k;
      end
    end
    CPU_MIO = 1'b0;
    checkOutput("held_pulses", 32'(pulses), 32'd4);
    checkOutput("held_first",  32'(first), 32'd3);
    @(posedge clk); #1;

    // Unmapped accesses: zero data, sticky error, no RAM aliasing.
    applyStimulus(1'b0, 32'h1000_0000, 32'h0, rd, lat);
    checkOutput("unmapped_rdata",   rd, 32'h0);
    checkOutput("unmapped_bus_err", {31'h0, bus_err}, 32'h1);
    applyStimulus(1'b1, 32'h0000_0100, 32'h9999_9999, rd, lat);
    applyStimulus(1'b0, 32'h0000_0000, 32'h0, rd, lat);
    checkOutput("no_alias_word0", rd, 32'h1111_1111);
    checkOutput("sticky_bus_err", {31'h0, bus_err}, 32'h1);

    // Reset while BUSY aborts the write and the ready pulse.
    applyStimulus(1'b1, 32'h0000_0008, 32'h7777_7777, rd, lat);
    CPU_MIO  = 1'b1;
    mem_w    = 1'b1;
    Addr_bus = 32'h0000_0008;
    Data_out = 32'h0000_0055;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready",   {31'h0, MIO_ready}, 32'h0);
    checkOutput("midrst_gpio",    {16'h0, gpio_o}, 32'h0);
    checkOutput("midrst_bus_err", {31'h0, bus_err}, 32'h0);
    CPU_MIO = 1'b0;
    mem_w   = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (MIO_ready) quiet++;
    end
    checkOutput("postrst_no_ready", 32'(quiet), 32'd0);
    applyStimulus(1'b0, 32'h0000_0008, 32'h0, rd, lat);
    checkOutput("aborted_write", rd, 32'h7777_7777);
    checkOutput("postrst_gpio", {16'h0, gpio_o}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
